// File: rtl/greater_than_cmp.sv
// Registered signed/unsigned magnitude comparator producing gt/eq/lt flags.
// Define GT_PIPE2_EN for a two-stage (latency 2) version built from registered half-word compares.
module greater_than_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             unsigned_mode,
    output logic             out_valid,
    output logic             out,
    output logic             eq,
    output logic             lt
);

    localparam int HALF = WIDTH / 2;
    localparam logic [HALF-1:0] HI_MSB = HALF'(1) << (HALF - 1);

    logic [HALF-1:0] hiA;
    logic [HALF-1:0] hiB;
    logic [HALF-1:0] loA;
    logic [HALF-1:0] loB;
    logic            hiGt;
    logic            hiEq;
    logic            loGt;
    logic            loEq;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the signed compare never overflows the way an A-B subtraction would.
    always_comb begin
        hiA  = in_a[WIDTH-1:HALF] ^ (unsigned_mode ? '0 : HI_MSB);
        hiB  = in_b[WIDTH-1:HALF] ^ (unsigned_mode ? '0 : HI_MSB);
        loA  = in_a[HALF-1:0];
        loB  = in_b[HALF-1:0];
        hiGt = (hiA > hiB);
        hiEq = (hiA == hiB);
        loGt = (loA > loB);
        loEq = (loA == loB);
    end

    logic gtComb;
    logic eqComb;
    logic resultValid;

`ifdef GT_PIPE2_EN
    logic stage1Valid;
    logic hiGtReg;
    logic hiEqReg;
    logic loGtReg;
    logic loEqReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1Valid <= 1'b0;
            hiGtReg     <= 1'b0;
            hiEqReg     <= 1'b0;
            loGtReg     <= 1'b0;
            loEqReg     <= 1'b0;
        end else begin
            stage1Valid <= in_valid;
            if (in_valid) begin
                hiGtReg <= hiGt;
                hiEqReg <= hiEq;
                loGtReg <= loGt;
                loEqReg <= loEq;
            end
        end
    end

    assign gtComb      = hiGtReg | (hiEqReg & loGtReg);
    assign eqComb      = hiEqReg & loEqReg;
    assign resultValid = stage1Valid;
`else
    assign gtComb      = hiGt | (hiEq & loGt);
    assign eqComb      = hiEq & loEq;
    assign resultValid = in_valid;
`endif

    // Flags only move on a valid result; an idle cycle just drops out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            out_valid <= resultValid;
            if (resultValid) begin
                out <= gtComb;
                eq  <= eqComb;
                lt  <= ~gtComb & ~eqComb;
            end
        end
    end

endmodule

// File: tb/tb_greater_than_cmp.sv
// Directed self-checking bench for greater_than_cmp (WIDTH=16); tracks GT_PIPE2_EN latency.
module tb_greater_than_cmp;

`ifdef GT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        unsigned_mode;
    logic        out_valid;
    logic        out;
    logic        eq;
    logic        lt;

    int testsRun    = 0;
    int testsFailed = 0;

    greater_than_cmp #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_a         (in_a),
        .in_b         (in_b),
        .unsigned_mode(unsigned_mode),
        .out_valid    (out_valid),
        .out          (out),
        .eq           (eq),
        .lt           (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // exp is {out, eq, lt}
    task automatic checkAll(input string tag, input logic expValid, input logic [2:0] exp);
        check({tag, ".valid"}, out_valid, expValid);
        check({tag, ".out"}, out, exp[2]);
        check({tag, ".eq"}, eq, exp[1]);
        check({tag, ".lt"}, lt, exp[0]);
    endtask

    task automatic runOne(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic u, input logic [2:0] exp);
        in_a          = a;
        in_b          = b;
        unsigned_mode = u;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        $display("[TB] %s a=%h b=%h unsigned=%b -> valid=%b out=%b eq=%b lt=%b",
                 tag, a, b, u, out_valid, out, eq, lt);
        checkAll(tag, 1'b1, exp);
    endtask

    logic [15:0] vecA   [8] = '{16'h0001, 16'h8001, 16'h8001, 16'h1234,
                                16'h00FF, 16'h0100, 16'hFF00, 16'h8000};
    logic [15:0] vecB   [8] = '{16'h0002, 16'h7FFF, 16'h7FFF, 16'h1234,
                                16'h0100, 16'h00FF, 16'hFEFF, 16'h8000};
    logic        vecU   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  vecExp [8] = '{3'b001, 3'b001, 3'b100, 3'b010,
                                3'b001, 3'b100, 3'b100, 3'b010};

    initial begin
        rst_n         = 1'b1;
        in_valid      = 1'b0;
        in_a          = '0;
        in_b          = '0;
        unsigned_mode = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("reset", 1'b0, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("idle", 1'b0, 3'b000);

        runOne("s_10_5",        16'h000A, 16'h0005, 1'b0, 3'b100);
        runOne("s_5_10",        16'h0005, 16'h000A, 1'b0, 3'b001);
        runOne("s_10_10",       16'h000A, 16'h000A, 1'b0, 3'b010);
        runOne("s_m4_m1",       16'hFFFC, 16'hFFFF, 1'b0, 3'b001);
        runOne("s_m1_m4",       16'hFFFF, 16'hFFFC, 1'b0, 3'b100);
        runOne("u_fffc_ffff",   16'hFFFC, 16'hFFFF, 1'b1, 3'b001);
        runOne("u_ffff_fffc",   16'hFFFF, 16'hFFFC, 1'b1, 3'b100);
        runOne("s_7fff_8000",   16'h7FFF, 16'h8000, 1'b0, 3'b100);
        runOne("u_7fff_8000",   16'h7FFF, 16'h8000, 1'b1, 3'b001);
        runOne("s_8000_0000",   16'h8000, 16'h0000, 1'b0, 3'b001);

        // Back-to-back stream: result j appears LAT edges after it is driven.
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) begin
                in_a          = vecA[i];
                in_b          = vecB[i];
                unsigned_mode = vecU[i];
                in_valid      = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= LAT - 1) begin
                $display("[TB] b2b[%0d] a=%h b=%h unsigned=%b -> valid=%b out=%b eq=%b lt=%b",
                         i - LAT + 1, vecA[i - LAT + 1], vecB[i - LAT + 1],
                         vecU[i - LAT + 1], out_valid, out, eq, lt);
                checkAll($sformatf("b2b%0d", i - LAT + 1), 1'b1, vecExp[i - LAT + 1]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkAll("b2b_hold", 1'b0, vecExp[7]);

        // Asynchronous reset while a result is valid and new operands are in flight.
        in_a          = 16'h000A;
        in_b          = 16'h0005;
        unsigned_mode = 1'b0;
        in_valid      = 1'b1;
        repeat (LAT) begin
            @(posedge clk);
            #1;
        end
        checkAll("rst_pre", 1'b1, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("rst_async", 1'b0, 3'b000);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_post%0d.valid", k), out_valid, 1'b0);
        end

        // Latency after release.
        in_a          = 16'h7FFF;
        in_b          = 16'h8000;
        unsigned_mode = 1'b0;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_edge1.valid", out_valid, (LAT == 1));
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        $display("[TB] lat a=7fff b=8000 unsigned=0 -> valid=%b out=%b eq=%b lt=%b",
                 out_valid, out, eq, lt);
        checkAll("lat_result", 1'b1, 3'b100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/greater_than_cmp.md
Name: greater_than_cmp

Overview:
- Registered signed/unsigned magnitude comparator for the demo1 datapath (SLT/SLE/SCO-style condition generation, branch compare).
- Takes two WIDTH-bit operands with a valid strobe; returns a registered greater-than result plus eq/lt flags.
- Default mode is two's-complement signed compare.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64, must be even.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present this cycle
- in_a  input  WIDTH  operand A (InA)
- in_b  input  WIDTH  operand B (InB)
- unsigned_mode  input  1  1 = unsigned compare; 0 = signed two's-complement (default use)
- out_valid  output  1  result valid
- out  output  1  1 iff A > B under selected mode
- eq  output  1  1 iff A == B (bitwise)
- lt  output  1  1 iff A < B under selected mode

Interface (Already decided):
- One clock (clk).
- Reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset: asserting rst_n low immediately clears out_valid, out, eq and lt to 0, regardless of clk. Deassertion is sampled synchronously on the next clk edge.
- Latency: 1 cycle.
  - Operands sampled on the rising edge with in_valid=1 produce out_valid=1 and their result on the following cycle.
  - No backpressure; a new operand pair may be accepted every cycle.
- in_valid=0 at an edge:
  - out_valid goes 0.
  - out, eq and lt hold their previous values.
- Signed mode (unsigned_mode=0):
  - Sign bits differ: A > B iff A's MSB is 0.
  - Sign bits equal: compare the remaining bits as unsigned.
  - Must not be implemented as A-B sign only; there must be no overflow error at extremes (0x7FFF vs 0x8000).
- Unsigned mode: plain magnitude compare over all WIDTH bits.
- Exactly one of out/eq/lt is 1 whenever out_valid=1.
- unsigned_mode is sampled together with the operands, on the same edge as in_valid.
- Reset mid-operation discards any in-flight result; out_valid is 0 until a new in_valid is accepted after release.
- X-free: outputs are fully defined after reset, even before the first in_valid.

Optional Feature:
- Macro: GT_PIPE2_EN
- Defined:
  - Two-stage pipeline, latency 2.
  - Stage 1 registers per-half results (upper-half gt/eq with sign handling, lower-half unsigned gt/eq).
  - Stage 2 combines them: gt = hi_gt | (hi_eq & lo_gt); eq = hi_eq & lo_eq.
  - Throughput remains 1/cycle; out_valid is delayed by 2 cycles.
  - in_valid=0 behaviour, hold behaviour and reset clearing apply to both stages.
- Undefined: single-stage, latency 1 as above.
- Functional results are identical in both builds apart from latency.

Test Plan:
- Signed, A=10 (0x000A), B=5 (0x0005), in_valid=1 -> next cycle out_valid=1, out=1, eq=0, lt=0.
- Signed, A=5, B=10 -> out=0, lt=1, eq=0; then A=10, B=10 -> out=0, eq=1, lt=0.
- Signed negatives:
  - A=0xFFFC (-4), B=0xFFFF (-1) -> out=0, lt=1.
  - A=0xFFFF, B=0xFFFC -> out=1.
  - Same pairs with unsigned_mode=1 -> 0xFFFC vs 0xFFFF out=0; 0xFFFF vs 0xFFFC out=1.
- Extremes:
  - Signed A=0x7FFF, B=0x8000 -> out=1.
  - Unsigned, same pair -> out=0, lt=1.
  - A=0x8000, B=0x0000 signed -> out=0, lt=1.
- Back-to-back operands every cycle for 8 cycles, then in_valid=0 -> one result per cycle in order; out_valid drops and flags hold.
- Assert rst_n low between clock edges while out_valid=1 -> all outputs 0 immediately. After release, no out_valid until a new in_valid; repeat with GT_PIPE2_EN and check latency is 2.
